// File: rtl/mips_multicycle_controller.sv
// Sequencing FSM for the multi-cycle MIPS datapath: drives every datapath control per state,
// waits on mem_ready and traps illegal instructions and memory timeouts into a sticky S_ERR.
module mips_multicycle_controller #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_load,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic [1:0] reg_dst,
   output logic [1:0] mem_to_reg,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_op,
   output logic [1:0] pc_src,
   output logic       instr_done,
   output logic       error,
   output logic [3:0] dbg_state
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
      S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_REX    = 4'd6,  S_RWB   = 4'd7,
      S_BEQ    = 4'd8,  S_IEX    = 4'd9,  S_IWB    = 4'd10, S_JUMP  = 4'd11,
      S_JR     = 4'd12, S_ERR    = 4'd13
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_JAL  = 6'b000011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_SLTI = 6'b001010;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;

   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_SLT = 6'b101010;
   localparam logic [5:0] F_JR  = 6'b001000;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b100;

   state_t           state, state_next;
   logic [CNT_W-1:0] wait_cnt;
   logic             waiting, timed_out;

   logic       pc_load_c, iord_c, mem_read_c, mem_write_c, ir_write_c;
   logic [1:0] reg_dst_c, mem_to_reg_c, alu_src_b_c, pc_src_c;
   logic       reg_write_c, alu_src_a_c, instr_done_c, error_c;
   logic [2:0] alu_op_c;

   assign waiting   = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
   assign timed_out = (MEM_TIMEOUT != 0) && (wait_cnt == CNT_W'(MEM_TIMEOUT));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_FETCH;
         wait_cnt <= '0;
      end else begin
         state <= state_next;
         // Any state change clears the counter, so every wait state is entered with zero.
         if (state_next != state)
            wait_cnt <= '0;
         else if (waiting && !mem_ready)
            wait_cnt <= wait_cnt + 1'b1;
      end
   end

   always_comb begin
      state_next   = state;
      pc_load_c    = 1'b0;
      iord_c       = 1'b0;
      mem_read_c   = 1'b0;
      mem_write_c  = 1'b0;
      ir_write_c   = 1'b0;
      reg_dst_c    = 2'b00;
      mem_to_reg_c = 2'b00;
      reg_write_c  = 1'b0;
      alu_src_a_c  = 1'b0;
      alu_src_b_c  = 2'b00;
      alu_op_c     = ALU_ADD;
      pc_src_c     = 2'b00;
      error_c      = 1'b0;
      case (state)
         S_FETCH: begin
            mem_read_c  = 1'b1;
            alu_src_b_c = 2'b01;
            // A completing access beats a timeout in the same cycle.
            if (mem_ready) begin
               ir_write_c = 1'b1;
               pc_load_c  = 1'b1;
               state_next = S_DECODE;
            end else if (timed_out) begin
               state_next = S_ERR;
            end
         end
         S_DECODE: begin
            alu_src_b_c = 2'b11;
            case (opcode)
               OP_LW, OP_SW:     state_next = S_MEMADR;
               OP_R:             state_next = S_REX;
               OP_BEQ:           state_next = S_BEQ;
               OP_ADDI, OP_SLTI: state_next = S_IEX;
               OP_J, OP_JAL:     state_next = S_JUMP;
               default:          state_next = S_ERR;
            endcase
         end
         S_MEMADR: begin
            alu_src_a_c = 1'b1;
            alu_src_b_c = 2'b10;
            state_next  = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            iord_c     = 1'b1;
            mem_read_c = 1'b1;
            if (mem_ready)      state_next = S_MEMWB;
            else if (timed_out) state_next = S_ERR;
         end
         S_MEMWB: begin
            mem_to_reg_c = 2'b01;
            reg_write_c  = 1'b1;
            state_next   = S_FETCH;
         end
         S_MEMWR: begin
            iord_c      = 1'b1;
            mem_write_c = 1'b1;
            if (mem_ready)      state_next = S_FETCH;
            else if (timed_out) state_next = S_ERR;
         end
         S_REX: begin
            alu_src_a_c = 1'b1;
            state_next  = S_RWB;
            case (funct)
               F_ADD:   alu_op_c = ALU_ADD;
               F_SUB:   alu_op_c = ALU_SUB;
               F_AND:   alu_op_c = ALU_AND;
               F_OR:    alu_op_c = ALU_OR;
               F_SLT:   alu_op_c = ALU_SLT;
               F_JR:    state_next = S_JR;
               default: state_next = S_ERR;
            endcase
         end
         S_RWB: begin
            reg_dst_c   = 2'b01;
            reg_write_c = 1'b1;
            state_next  = S_FETCH;
         end
         S_BEQ: begin
            alu_src_a_c = 1'b1;
            alu_op_c    = ALU_SUB;
            pc_src_c    = 2'b01;
            pc_load_c   = zero;
            state_next  = S_FETCH;
         end
         S_IEX: begin
            alu_src_a_c = 1'b1;
            alu_src_b_c = 2'b10;
            alu_op_c    = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
            state_next  = S_IWB;
         end
         S_IWB: begin
            reg_write_c = 1'b1;
            state_next  = S_FETCH;
         end
         S_JUMP: begin
            pc_src_c   = 2'b10;
            pc_load_c  = 1'b1;
            // jal links the already-incremented PC into $31.
            if (opcode == OP_JAL) begin
               reg_write_c  = 1'b1;
               reg_dst_c    = 2'b10;
               mem_to_reg_c = 2'b10;
            end
            state_next = S_FETCH;
         end
         S_JR: begin
            pc_src_c   = 2'b11;
            pc_load_c  = 1'b1;
            state_next = S_FETCH;
         end
         S_ERR:   error_c    = 1'b1;
         default: state_next = S_ERR;
      endcase
      instr_done_c = (state_next == S_FETCH) && (state != S_FETCH);
   end

   // Outputs are gated by rst so an asynchronous reset drops strobes mid-access.
   assign pc_load    = rst & pc_load_c;
   assign iord       = rst & iord_c;
   assign mem_read   = rst & mem_read_c;
   assign mem_write  = rst & mem_write_c;
   assign ir_write   = rst & ir_write_c;
   assign reg_dst    = {2{rst}} & reg_dst_c;
   assign mem_to_reg = {2{rst}} & mem_to_reg_c;
   assign reg_write  = rst & reg_write_c;
   assign alu_src_a  = rst & alu_src_a_c;
   assign alu_src_b  = {2{rst}} & alu_src_b_c;
   assign alu_op     = {3{rst}} & alu_op_c;
   assign pc_src     = {2{rst}} & pc_src_c;
   assign instr_done = rst & instr_done_c;
   assign error      = rst & error_c;
   assign dbg_state  = state;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Directed bench for mips_multicycle_controller: per-cycle state and packed control vector
// checked against hand-written expectations for each instruction class and failure path.
module tb_mips_multicycle_controller;

   localparam logic [3:0] FETCH = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2, MEMRD = 4'd3,
                          MEMWB = 4'd4,  MEMWR  = 4'd5,  REX    = 4'd6, RWB   = 4'd7,
                          BEQ   = 4'd8,  IEX    = 4'd9,  IWB    = 4'd10, JUMP = 4'd11,
                          JR    = 4'd12, ERR    = 4'd13;

   logic       clk, rst;
   logic [5:0] opcode, funct;
   logic       zero, mem_ready;
   logic       pc_load, iord, mem_read, mem_write, ir_write;
   logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_src;
   logic       reg_write, alu_src_a, instr_done, error;
   logic [2:0] alu_op;
   logic [3:0] dbg_state;
   logic [19:0] got;

   int n_cmp = 0;
   int n_bad = 0;
   int done_seen;
   int irw_seen;

   mips_multicycle_controller #(.MEM_TIMEOUT(15), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .pc_load(pc_load), .iord(iord), .mem_read(mem_read),
      .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
      .instr_done(instr_done), .error(error), .dbg_state(dbg_state)
   );

   // {pc_load,iord,mem_read,mem_write,ir_write,reg_dst,mem_to_reg,reg_write,src_a,src_b,alu_op,pc_src,done,error}
   function automatic logic [19:0] ctl(input logic f_pcl, input logic f_iord, input logic f_rd,
                                       input logic f_wr, input logic f_irw, input logic [1:0] f_dst,
                                       input logic [1:0] f_m2r, input logic f_rw, input logic f_sa,
                                       input logic [1:0] f_sb, input logic [2:0] f_op,
                                       input logic [1:0] f_ps, input logic f_done, input logic f_err);
      return {f_pcl, f_iord, f_rd, f_wr, f_irw, f_dst, f_m2r, f_rw, f_sa, f_sb, f_op, f_ps, f_done, f_err};
   endfunction

   assign got = ctl(pc_load, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                    alu_src_a, alu_src_b, alu_op, pc_src, instr_done, error);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      n_cmp++;
      if (actual !== expected) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   // Settle, check state and controls, then advance to just after the next rising edge.
   task automatic step(input string tag, input logic [3:0] st, input logic [19:0] exp_ctl);
      #1;
      check_eq({tag, "_state"}, 32'(dbg_state), 32'(st));
      check_eq({tag, "_ctl"}, 32'(got), 32'(exp_ctl));
      done_seen += int'(instr_done);
      irw_seen  += int'(ir_write);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      mem_ready = 1'b0;
      #1;
      check_eq("reset_ctl", 32'(got), 32'd0);
      check_eq("reset_state", 32'(dbg_state), 32'(FETCH));
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   task automatic fetch_decode(input string tag, input logic [5:0] op, input logic [5:0] fn);
      opcode = op;
      funct = fn;
      mem_ready = 1'b1;
      step({tag, "_fetch"}, FETCH, ctl(1,0,1,0,1,2'b00,2'b00,0,0,2'b01,3'b000,2'b00,0,0));
      mem_ready = 1'b0;
      step({tag, "_decode"}, DECODE, ctl(0,0,0,0,0,2'b00,2'b00,0,0,2'b11,3'b000,2'b00,0,0));
   endtask

   initial begin
      rst = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
      done_seen = 0; irw_seen = 0;
      do_reset();

      // lw $2, 4($1) = 0x8C220004, zero-wait memory
      done_seen = 0;
      fetch_decode("lw", 6'b100011, 6'b000100);
      step("lw_memadr", MEMADR, ctl(0,0,0,0,0,2'b00,2'b00,0,1,2'b10,3'b000,2'b00,0,0));
      mem_ready = 1'b1;
      step("lw_memrd", MEMRD, ctl(0,1,1,0,0,2'b00,2'b00,0,0,2'b00,3'b000,2'b00,0,0));
      mem_ready = 1'b0;
      step("lw_memwb", MEMWB, ctl(0,0,0,0,0,2'b00,2'b01,1,0,2'b00,3'b000,2'b00,1,0));
      check_eq("lw_done_count", 32'(done_seen), 32'd1);

      // beq 0x10000003, taken then not taken
      fetch_decode("beq1", 6'b000100, 6'b000011);
      zero = 1'b1;
      step("beq1_exec", BEQ, ctl(1,0,0,0,0,2'b00,2'b00,0,1,2'b00,3'b001,2'b01,1,0));
      fetch_decode("beq0", 6'b000100, 6'b000011);
      zero = 1'b0;
      step("beq0_exec", BEQ, ctl(0,0,0,0,0,2'b00,2'b00,0,1,2'b00,3'b001,2'b01,1,0));

      // sw with three wait cycles
      fetch_decode("sw", 6'b101011, 6'b000000);
      step("sw_memadr", MEMADR, ctl(0,0,0,0,0,2'b00,2'b00,0,1,2'b10,3'b000,2'b00,0,0));
      for (int i = 0; i < 3; i++)
         step("sw_wait", MEMWR, ctl(0,1,0,1,0,2'b00,2'b00,0,0,2'b00,3'b000,2'b00,0,0));
      mem_ready = 1'b1;
      step("sw_done", MEMWR, ctl(0,1,0,1,0,2'b00,2'b00,0,0,2'b00,3'b000,2'b00,1,0));
      mem_ready = 1'b0;
      step("sw_back", FETCH, ctl(0,0,1,0,0,2'b00,2'b00,0,0,2'b01,3'b000,2'b00,0,0));

      // R-type add and or
      fetch_decode("add", 6'b000000, 6'b100000);
      step("add_rex", REX, ctl(0,0,0,0,0,2'b00,2'b00,0,1,2'b00,3'b000,2'b00,0,0));
      step("add_rwb", RWB, ctl(0,0,0,0,0,2'b01,2'b00,1,0,2'b00,3'b000,2'b00,1,0));
      fetch_decode("or", 6'b000000, 6'b100101);
      step("or_rex", REX, ctl(0,0,0,0,0,2'b00,2'b00,0,1,2'b00,3'b011,2'b00,0,0));
      step("or_rwb", RWB, ctl(0,0,0,0,0,2'b01,2'b00,1,0,2'b00,3'b000,2'b00,1,0));

      // addi and slti
      fetch_decode("addi", 6'b001000, 6'b000101);
      step("addi_iex", IEX, ctl(0,0,0,0,0,2'b00,2'b00,0,1,2'b10,3'b000,2'b00,0,0));
      step("addi_iwb", IWB, ctl(0,0,0,0,0,2'b00,2'b00,1,0,2'b00,3'b000,2'b00,1,0));
      fetch_decode("slti", 6'b001010, 6'b000101);
      step("slti_iex", IEX, ctl(0,0,0,0,0,2'b00,2'b00,0,1,2'b10,3'b100,2'b00,0,0));
      step("slti_iwb", IWB, ctl(0,0,0,0,0,2'b00,2'b00,1,0,2'b00,3'b000,2'b00,1,0));

      // jr, j, jal 0x0C000010
      fetch_decode("jr", 6'b000000, 6'b001000);
      step("jr_rex", REX, ctl(0,0,0,0,0,2'b00,2'b00,0,1,2'b00,3'b000,2'b00,0,0));
      step("jr_exec", JR, ctl(1,0,0,0,0,2'b00,2'b00,0,0,2'b00,3'b000,2'b11,1,0));
      fetch_decode("j", 6'b000010, 6'b010000);
      step("j_exec", JUMP, ctl(1,0,0,0,0,2'b00,2'b00,0,0,2'b00,3'b000,2'b10,1,0));
      fetch_decode("jal", 6'b000011, 6'b010000);
      step("jal_exec", JUMP, ctl(1,0,0,0,0,2'b10,2'b10,1,0,2'b00,3'b000,2'b10,1,0));

      // illegal funct, then illegal opcode
      fetch_decode("badfn", 6'b000000, 6'b000001);
      step("badfn_rex", REX, ctl(0,0,0,0,0,2'b00,2'b00,0,1,2'b00,3'b000,2'b00,0,0));
      mem_ready = 1'b1;
      step("badfn_err", ERR, ctl(0,0,0,0,0,2'b00,2'b00,0,0,2'b00,3'b000,2'b00,0,1));
      step("badfn_sticky", ERR, ctl(0,0,0,0,0,2'b00,2'b00,0,0,2'b00,3'b000,2'b00,0,1));
      do_reset();
      fetch_decode("badop", 6'b111111, 6'b000000);
      step("badop_err", ERR, ctl(0,0,0,0,0,2'b00,2'b00,0,0,2'b00,3'b000,2'b00,0,1));
      do_reset();

      // fetch timeout: 16 cycles in FETCH with mem_ready low, then sticky error
      irw_seen = 0;
      for (int i = 0; i < 16; i++)
         step("to_wait", FETCH, ctl(0,0,1,0,0,2'b00,2'b00,0,0,2'b01,3'b000,2'b00,0,0));
      mem_ready = 1'b1;
      for (int i = 0; i < 3; i++)
         step("to_err", ERR, ctl(0,0,0,0,0,2'b00,2'b00,0,0,2'b00,3'b000,2'b00,0,1));
      check_eq("to_no_ir_write", 32'(irw_seen), 32'd0);
      do_reset();

      // mem_ready arriving on the limit cycle completes the fetch
      for (int i = 0; i < 15; i++)
         step("lim_wait", FETCH, ctl(0,0,1,0,0,2'b00,2'b00,0,0,2'b01,3'b000,2'b00,0,0));
      mem_ready = 1'b1;
      step("lim_fetch", FETCH, ctl(1,0,1,0,1,2'b00,2'b00,0,0,2'b01,3'b000,2'b00,0,0));
      mem_ready = 1'b0;
      opcode = 6'b100011;
      step("lim_decode", DECODE, ctl(0,0,0,0,0,2'b00,2'b00,0,0,2'b11,3'b000,2'b00,0,0));

      // asynchronous reset in the middle of a stalled load
      step("rst_memadr", MEMADR, ctl(0,0,0,0,0,2'b00,2'b00,0,1,2'b10,3'b000,2'b00,0,0));
      step("rst_memrd", MEMRD, ctl(0,1,1,0,0,2'b00,2'b00,0,0,2'b00,3'b000,2'b00,0,0));
      rst = 1'b0;
      #1;
      check_eq("rst_mid_ctl", 32'(got), 32'd0);
      check_eq("rst_mid_state", 32'(dbg_state), 32'(FETCH));
      @(posedge clk);
      #1;
      rst = 1'b1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
